// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I instruction-memory loader.
// Holds the loader FSM encoding and the fixed framing byte counts.
package rv32i_pkg;

  localparam int XLEN           = 32;
  localparam int BYTES_PER_WORD = XLEN / 8;
  localparam int HDR_BYTES      = 2;
  localparam int CSUM_BYTES     = 1;

  typedef enum logic [2:0] {
    ST_LEN_LO  = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } loader_state_e;

endpackage

// File: rtl/word_packer_rv32i.sv
// Packs payload bytes little-endian into 32-bit words; o_word_vld is combinational on the 4th byte.
// No backpressure of its own: the caller only presents bytes it has already accepted.
module word_packer_rv32i
  import rv32i_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            i_byte_vld,
  input  logic [7:0]      i_byte_dat,
  output logic            o_word_vld,
  output logic [XLEN-1:0] o_word_dat
);

  logic [1:0]  r_byte_idx;
  logic [23:0] r_lo_bytes;

  assign o_word_vld = i_byte_vld && (r_byte_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word_dat = {i_byte_dat, r_lo_bytes};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_byte_idx <= 2'd0;
      r_lo_bytes <= 24'd0;
    end else if (i_byte_vld) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      case (r_byte_idx)
        2'd0:    r_lo_bytes[7:0]   <= i_byte_dat;
        2'd1:    r_lo_bytes[15:8]  <= i_byte_dat;
        2'd2:    r_lo_bytes[23:16] <= i_byte_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader_rv32i.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory, then releases the core.
// Writes land one cycle after a word's last byte; s_ready drops only in DONE/ERR or reset.
module imem_loader_rv32i
  import rv32i_pkg::*;
#(
  parameter int              IMEM_WORDS = 256,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  output logic            s_ready,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            core_reset,
  output logic            done,
  output logic            error
);

  loader_state_e   r_state;
  logic [15:0]     r_len;
  logic [15:0]     r_word_cnt;
  logic [7:0]      r_csum;
  logic            r_imem_we;
  logic [XLEN-1:0] r_imem_addr;
  logic [XLEN-1:0] r_imem_wdata;
  logic            r_core_reset;
  logic            r_done;
  logic            r_error;

  logic            w_accept;
  logic            w_pay_vld;
  logic            w_word_vld;
  logic [XLEN-1:0] w_word_dat;
  logic [XLEN-1:0] w_word_addr;
  logic [15:0]     w_len_full;
  logic            w_last_word;

  always_comb begin
    s_ready = !reset && (r_state == ST_LEN_LO || r_state == ST_LEN_HI ||
                         r_state == ST_PAYLOAD || r_state == ST_CHECK);
  end

  assign w_accept    = s_valid && s_ready;
  assign w_pay_vld   = w_accept && (r_state == ST_PAYLOAD);
  assign w_len_full  = {s_data, r_len[7:0]};
  assign w_word_addr = BASE_ADDR + {14'd0, r_word_cnt, 2'b00};
  assign w_last_word = (r_word_cnt + 16'd1) == r_len;

  word_packer_rv32i u_packer (
    .clock      (clock),
    .reset      (reset),
    .i_byte_vld (w_pay_vld),
    .i_byte_dat (s_data),
    .o_word_vld (w_word_vld),
    .o_word_dat (w_word_dat)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_LEN_LO;
      r_len        <= 16'd0;
      r_word_cnt   <= 16'd0;
      r_csum       <= 8'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      if (w_word_vld) begin
        r_imem_we    <= 1'b1;
        r_imem_addr  <= w_word_addr;
        r_imem_wdata <= w_word_dat;
        r_word_cnt   <= r_word_cnt + 16'd1;
      end
      if (w_accept) begin
        case (r_state)
          ST_LEN_LO: begin
            r_len[7:0] <= s_data;
            r_state    <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            r_len <= w_len_full;
            if ({16'd0, w_len_full} > 32'(IMEM_WORDS)) begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end else if (w_len_full == 16'd0) begin
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            r_csum <= r_csum + s_data;
            if (w_word_vld && w_last_word) r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            // Core stays in reset on a bad checksum; only a good image is released.
            if (s_data == r_csum) begin
              r_state      <= ST_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_reset = r_core_reset;
  assign done       = r_done;
  assign error      = r_error;

endmodule
